// File: rtl/bu_pipe_if.sv
// Butterfly unit stream bundle: input operands/mode/tag and result channel, each with valid/ready.
interface bu_pipe_if #(
    parameter int W     = 12,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     u_in;
    logic [W-1:0]     t_in;
    logic [W-1:0]     coef;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     U_out;
    logic [W-1:0]     T_out;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, u_in, t_in, coef, mode, tag_in, out_ready,
        input  in_ready, out_valid, U_out, T_out, tag_out
    );

    modport slave (
        input  in_valid, u_in, t_in, coef, mode, tag_in, out_ready,
        output in_ready, out_valid, U_out, T_out, tag_out
    );
endinterface

// File: rtl/bu_pipe.sv
// Pipelined Kyber butterfly (NTT / INVNTT / pointwise mul / add-sub), MUL_LAT+3 cycle latency, in order.
// Backpressure: a held result freezes every stage; in_ready drops combinationally while stalled.
module bu_pipe #(
    parameter int W       = 12,
    parameter int Q       = 3329,
    parameter int MUL_LAT = 4,
    parameter int TAG_W   = 8
) (
    input  logic     clk,
    input  logic     rst,
    bu_pipe_if.slave bus
);
    localparam int             K  = 2 * W;
    localparam logic [W:0]     QX = (W + 1)'(Q);
    localparam logic [2*W-1:0] QL = (2 * W)'(Q);
    localparam logic [2*W-1:0] MU = (2 * W)'((64'd1 << K) / 64'(Q));

    typedef struct packed {
        logic             vld;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     u;
        logic [W-1:0]     t;
        logic [W-1:0]     c;
    } stg_t;

    // x holds the raw product while in flight, the reduced t once it leaves the last stage
    typedef struct packed {
        logic             vld;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     u;
        logic [2*W-1:0]   x;
    } mst_t;

    function automatic logic [W-1:0] add_q(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= QX) s = s - QX;
        return W'(s);
    endfunction

    function automatic logic [W-1:0] sub_q(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, a} + QX - {1'b0, b};
        return W'(d);
    endfunction

    function automatic logic [W-1:0] half_q(input logic [W-1:0] x);
        logic [W:0] h;
        h = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
        return W'(h >> 1);
    endfunction

    // Barrett reduction: quotient estimate is short by at most one, so a single correction suffices
    function automatic logic [W-1:0] mod_q(input logic [2*W-1:0] x);
        logic [4*W-1:0] prod;
        logic [2*W-1:0] qh;
        logic [2*W-1:0] r;
        prod = {{2*W{1'b0}}, x} * {{2*W{1'b0}}, MU};
        qh   = (2 * W)'(prod >> K);
        r    = x - qh * QL;
        if (r >= QL) r = r - QL;
        return W'(r);
    endfunction

    logic         stall;
    stg_t         s0;
    stg_t         s1;
    stg_t         s1_nxt;
    mst_t         m_q [MUL_LAT];
    mst_t         m_d [MUL_LAT];
    mst_t         ml;
    logic [W-1:0] ml_t;
    logic [W-1:0] post_u;
    logic [W-1:0] post_t;

    logic             out_vld;
    logic [W-1:0]     u_o;
    logic [W-1:0]     t_o;
    logic [TAG_W-1:0] tag_o;

    assign stall         = out_vld && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_vld;
    assign bus.U_out     = u_o;
    assign bus.T_out     = t_o;
    assign bus.tag_out   = tag_o;

    always_comb begin
        s1_nxt = s0;
        case (s0.mode)
            2'd1: begin
                s1_nxt.u = half_q(add_q(s0.u, s0.t));
                s1_nxt.t = half_q(sub_q(s0.u, s0.t));
            end
            2'd3: begin
                s1_nxt.u = add_q(s0.u, s0.t);
                s1_nxt.t = sub_q(s0.u, s0.t);
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < MUL_LAT; i++) begin
            if (i == 0) begin
                m_d[0].vld  = s1.vld;
                m_d[0].mode = s1.mode;
                m_d[0].tag  = s1.tag;
                m_d[0].u    = s1.u;
                m_d[0].x    = (s1.mode == 2'd3) ? {{W{1'b0}}, s1.t}
                                                : {{W{1'b0}}, s1.t} * {{W{1'b0}}, s1.c};
            end else begin
                m_d[i] = m_q[i-1];
            end
            if (i == MUL_LAT - 1 && m_d[i].mode != 2'd3)
                m_d[i].x = {{W{1'b0}}, mod_q(m_d[i].x)};
        end
    end

    assign ml   = m_q[MUL_LAT-1];
    assign ml_t = W'(ml.x);

    always_comb begin
        post_u = ml.u;
        post_t = ml_t;
        if (ml.mode == 2'd0) begin
            post_u = add_q(ml.u, ml_t);
            post_t = sub_q(ml.u, ml_t);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0 <= '0;
            s1 <= '0;
            for (int i = 0; i < MUL_LAT; i++) m_q[i] <= '0;
            out_vld <= 1'b0;
            u_o     <= '0;
            t_o     <= '0;
            tag_o   <= '0;
        end else if (!stall) begin
            s0.vld  <= bus.in_valid;
            s0.mode <= bus.mode;
            s0.tag  <= bus.tag_in;
            s0.u    <= bus.u_in;
            s0.t    <= bus.t_in;
            s0.c    <= bus.coef;
            s1      <= s1_nxt;
            for (int i = 0; i < MUL_LAT; i++) m_q[i] <= m_d[i];
            out_vld <= ml.vld;
            u_o     <= post_u;
            t_o     <= post_t;
            tag_o   <= ml.tag;
        end
    end
endmodule

// File: doc/bu_pipe.md
Name: bu_pipe

Overview:
- Parametrised, fully pipelined Kyber butterfly unit with valid/ready handshakes.
- Supports NTT, INVNTT, pointwise-multiply stage 1 and poly add/sub.
- Each transaction carries its own mode and sideband tag, so modes can change on any cycle with no flush.
- Latency is the same for every mode and results leave in order. Sits between the NTT controller/poly RAM read ports and the write-back path.

Parameters:
W, 12, coefficient width in bits; must satisfy Q < 2^W.
Q, 3329, modulus.
MUL_LAT, 4, register stages inside the modular multiplier; minimum 1.
TAG_W, 8, width of the sideband tag (write address/bank) carried with each transaction.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous active-low reset; rst=0 resets.
in_valid  input  1  input transaction present.
in_ready  output  1  block can accept input this cycle.
u_in  input  W  u operand, in [0,Q).
t_in  input  W  t operand, in [0,Q).
coef  input  W  twiddle or multiplier, in [0,Q).
mode  input  2  0 NTT/mul stage 2; 1 INVNTT; 2 mul stage 1; 3 add/sub.
tag_in  input  TAG_W  sideband tag, passed through unchanged.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts result.
U_out  output  W  U result, canonical in [0,Q).
T_out  output  W  T result, canonical in [0,Q).
tag_out  output  TAG_W  tag of the result currently on the outputs.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits clear; out_valid=0, U_out=0, T_out=0, tag_out=0.
  - in_ready=1 after reset.
  - Reset mid-operation discards all in-flight transactions.
- Handshake:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
  - stall = out_valid && !out_ready. While stalled, every stage holds all of its registers.
  - in_ready = !stall (combinational).
  - Bubbles (valid=0) advance normally.
  - out_valid, U_out, T_out and tag_out stay stable while stalled.
- Pipeline (LAT = MUL_LAT+3 register stages; default 7). Each stage carries {valid, mode, tag, u, t, coef}:
  - S0: input register.
  - S1: pre-add/sub. Mode 1: u'=(u+t)/2 mod Q, t'=(u-t)/2 mod Q. Mode 3: u'=u+t mod Q, t'=u-t mod Q. Modes 0/2: pass.
  - S2..S(MUL_LAT+1): multiplier. Modes 0/1/2: t'=t*coef mod Q, u delayed alongside. Mode 3: pass.
  - S(MUL_LAT+2): post-add/sub and output register. Mode 0: U=u+t mod Q, T=u-t mod Q. Other modes: pass.
- Throughput and timing:
  - Throughput is one transaction per cycle with no stall.
  - A transaction accepted on edge N appears on the outputs after edge N+MUL_LAT+2, provided there was no stall.
- Resulting functions:
  - Mode 0: U=u+t*c, T=u-t*c.
  - Mode 1: U=(u+t)/2, T=((u-t)/2)*c.
  - Mode 2: U=u, T=t*c.
  - Mode 3: U=u+t, T=u-t.
- Arithmetic rules:
  - All results are mod Q and canonical.
  - Subtraction adds Q when negative.
  - Halving of reduced x: x/2 if x is even, else (x+Q)/2.
  - Multiply is the exact product mod Q, with no Montgomery factor visible at the ports.
- Order: strictly in order. Mixed modes back-to-back never conflict, because each stage acts on its own carried mode.
- Operands >= Q: result unspecified, but the handshake must be unaffected.

Test Plan:
- Mode 0, u=100, t=2, coef=17 → after LAT, U_out=134, T_out=66; tag passes through; out_valid asserted exactly MUL_LAT+2 edges after the capture edge.
- Mode 1, u=5, t=2, coef=10 → U_out=1668 (7/2 mod 3329), T_out=15; mode 3, u=3000, t=400 → U_out=71, T_out=2600; mode 3, u=0, t=1 → T_out=3328.
- Mode 2, u=7, t=3328, coef=3328 → U_out=7, T_out=1; then issue modes 0,1,2,3 on consecutive cycles → four results on consecutive cycles, in order, each matching a reference model.
- Backpressure: stream 20 random transactions, hold out_ready=0 for 5 cycles mid-stream → in_ready=0 and outputs frozen for those cycles, with no loss or duplication; 20 results in order.
- Reset mid-stream: drive rst=0 asynchronously with 3 transactions in flight → out_valid, U_out, T_out and tag_out go to 0 immediately; after release, in_ready=1 and no stale results appear.
- Random regression: 10k transactions with random in_valid/out_ready and random mode → every result matches a golden model for Q=3329; repeat with MUL_LAT=1 and MUL_LAT=6.
